// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard controller: stalls the front end while a branch operand
// waits on load data, flushes IF/ID on a taken branch, and counts both events.
module branch_hazard_ctrl #(
  parameter logic [1:0] LOAD_SEL     = 2'd1,
  parameter bit         EX_ALU_STALL = 1'b0,
  parameter int         CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_stall,
  input  logic             id_branch,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rw,
  input  logic             ex_regWr,
  input  logic [1:0]       ex_memtoreg,
  input  logic [4:0]       mem_rw,
  input  logic             mem_regWr,
  input  logic [1:0]       mem_memtoreg,
  input  logic             branch_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {IDLE, STALL, RESOLVE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             ex_load, mem_load, ex_alu;
  logic [1:0]       need;
  logic             stall, flush;

  function automatic logic dep(input logic [4:0] r, input logic [4:0] rs,
                               input logic [4:0] rt);
    return (r != 5'd0) && ((r == rs) || (r == rt));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    ex_load  = ex_regWr && (ex_memtoreg == LOAD_SEL) && dep(ex_rw, id_rs, id_rt);
    mem_load = mem_regWr && (mem_memtoreg == LOAD_SEL) && dep(mem_rw, id_rs, id_rt);
    ex_alu   = EX_ALU_STALL && ex_regWr && !ex_load && dep(ex_rw, id_rs, id_rt);
    need     = 2'd0;
    if (id_branch) begin
      if (ex_load)                need = 2'd2;
      else if (mem_load || ex_alu) need = 2'd1;
    end
  end

  // The IDLE cycle that detects the hazard is itself the first stall cycle, so
  // STALL is entered with rem already counting that cycle and lasts rem cycles.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (need != 2'd0) begin
          stall = 1'b1;
          if (need == 2'd2) begin
            state_d = STALL;
            rem_d   = need - 2'd1;
          end else begin
            state_d = RESOLVE;
          end
        end
      end
      STALL: begin
        stall = 1'b1;
        if (rem_q <= 2'd1) begin
          state_d = RESOLVE;
          rem_d   = 2'd0;
        end else begin
          rem_d = rem_q - 2'd1;
        end
      end
      RESOLVE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        rem_d   = 2'd0;
      end
    endcase
    if (ext_stall) begin
      state_d = state_q;
      rem_d   = rem_q;
    end
  end

  assign flush = id_branch && branch_taken && !stall && !ext_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= sat_inc(stall_cnt_q, stall && !ext_stall);
      flush_cnt_q <= sat_inc(flush_cnt_q, flush);
    end
  end

  assign pc_stall    = stall;
  assign ifid_stall  = stall;
  assign idex_bubble = stall;
  assign ifid_flush  = flush;
  assign busy        = (state_q != IDLE);
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: a default instance (A) and an instance with
// the EX ALU stall enabled and 2-bit counters (B) share the same stimulus.
module tb_branch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, ext_stall, id_branch, branch_taken;
  logic [4:0] id_rs, id_rt, ex_rw, mem_rw;
  logic       ex_regWr, mem_regWr;
  logic [1:0] ex_memtoreg, mem_memtoreg;

  logic        a_pc, a_ifid, a_bub, a_flush, a_busy;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_pc, b_ifid, b_bub, b_flush, b_busy;
  logic [1:0]  b_scnt, b_fcnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl u_a (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_branch(id_branch),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rw(ex_rw), .ex_regWr(ex_regWr),
    .ex_memtoreg(ex_memtoreg), .mem_rw(mem_rw), .mem_regWr(mem_regWr),
    .mem_memtoreg(mem_memtoreg), .branch_taken(branch_taken),
    .pc_stall(a_pc), .ifid_stall(a_ifid), .idex_bubble(a_bub), .ifid_flush(a_flush),
    .busy(a_busy), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  branch_hazard_ctrl #(.EX_ALU_STALL(1'b1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_branch(id_branch),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rw(ex_rw), .ex_regWr(ex_regWr),
    .ex_memtoreg(ex_memtoreg), .mem_rw(mem_rw), .mem_regWr(mem_regWr),
    .mem_memtoreg(mem_memtoreg), .branch_taken(branch_taken),
    .pc_stall(b_pc), .ifid_stall(b_ifid), .idex_bubble(b_bub), .ifid_flush(b_flush),
    .busy(b_busy), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic st, input logic fl, input logic bz);
    chk({tag, ".a_pc_stall"}, 32'(a_pc), 32'(st));
    chk({tag, ".a_ifid_stall"}, 32'(a_ifid), 32'(st));
    chk({tag, ".a_idex_bubble"}, 32'(a_bub), 32'(st));
    chk({tag, ".a_ifid_flush"}, 32'(a_flush), 32'(fl));
    chk({tag, ".a_busy"}, 32'(a_busy), 32'(bz));
  endtask

  task automatic chk_b(input string tag, input logic st, input logic fl, input logic bz);
    chk({tag, ".b_pc_stall"}, 32'(b_pc), 32'(st));
    chk({tag, ".b_ifid_flush"}, 32'(b_flush), 32'(fl));
    chk({tag, ".b_busy"}, 32'(b_busy), 32'(bz));
  endtask

  task automatic clear_in();
    ext_stall = 0; id_branch = 0; branch_taken = 0; id_rs = 0; id_rt = 0;
    ex_rw = 0; ex_regWr = 0; ex_memtoreg = 0;
    mem_rw = 0; mem_regWr = 0; mem_memtoreg = 0;
  endtask

  // beq/bne $rs,$rt in ID with lw $5 in EX
  task automatic ex_lw_branch(input logic tk);
    clear_in();
    id_branch = 1; branch_taken = tk; id_rs = 5'd5; id_rt = 5'd6;
    ex_rw = 5'd5; ex_regWr = 1; ex_memtoreg = 2'd1;
  endtask

  initial begin
    rst = 1;
    clear_in();
    tick();
    tick();
    rst = 0;
    #1;
    chk_a("reset", 0, 0, 0);
    chk("reset.a_stall_cnt", 32'(a_scnt), 0);
    chk("reset.a_flush_cnt", 32'(a_fcnt), 0);

    // Test 1: lw $5 in EX, beq $5,$6
    ex_lw_branch(1'b0);
    #1;
    chk_a("t1.detect", 1, 0, 0);
    chk_b("t1.detect", 1, 0, 0);
    tick();
    clear_in();
    id_branch = 1; id_rs = 5'd5; id_rt = 5'd6;
    mem_rw = 5'd5; mem_regWr = 1; mem_memtoreg = 2'd1;
    #1;
    chk_a("t1.stall2", 1, 0, 1);
    chk_b("t1.stall2", 1, 0, 1);
    tick();
    mem_regWr = 0;
    #1;
    chk_a("t1.resolve", 0, 0, 1);
    tick();
    id_branch = 0;
    #1;
    chk_a("t1.idle", 0, 0, 0);
    chk("t1.a_stall_cnt", 32'(a_scnt), 2);
    chk("t1.b_stall_cnt", 32'(b_scnt), 2);

    // Test 2: lw $5 in MEM only, bne $0,$5 taken
    clear_in();
    id_branch = 1; branch_taken = 1; id_rs = 5'd0; id_rt = 5'd5;
    mem_rw = 5'd5; mem_regWr = 1; mem_memtoreg = 2'd1;
    #1;
    chk_a("t2.detect", 1, 0, 0);
    tick();
    #1;
    chk_a("t2.resolve", 0, 1, 1);
    chk_b("t2.resolve", 0, 1, 1);
    tick();
    id_branch = 0;
    #1;
    chk_a("t2.idle", 0, 0, 0);
    chk("t2.a_flush_cnt", 32'(a_fcnt), 1);
    chk("t2.a_stall_cnt", 32'(a_scnt), 3);
    chk("t2.b_stall_cnt", 32'(b_scnt), 3);

    // Test 3: add $7 in EX, beq $7,$7 (A: no stall, B: one stall)
    clear_in();
    id_branch = 1; id_rs = 5'd7; id_rt = 5'd7;
    ex_rw = 5'd7; ex_regWr = 1; ex_memtoreg = 2'd0;
    #1;
    chk_a("t3.detect", 0, 0, 0);
    chk_b("t3.detect", 1, 0, 0);
    tick();
    #1;
    chk_a("t3.next", 0, 0, 0);
    chk_b("t3.resolve", 0, 0, 1);
    chk("t3.a_stall_cnt", 32'(a_scnt), 3);
    chk("t3.b_stall_cnt_sat", 32'(b_scnt), 3);
    id_branch = 0;
    tick();

    // Test 4: lw $0 in EX, beq $0,$0 taken -> immediate flush
    clear_in();
    id_branch = 1; branch_taken = 1;
    ex_rw = 5'd0; ex_regWr = 1; ex_memtoreg = 2'd1;
    #1;
    chk_a("t4.r0", 0, 1, 0);
    chk_b("t4.r0", 0, 1, 0);
    tick();
    id_branch = 0;
    #1;
    chk("t4.a_flush_cnt", 32'(a_fcnt), 2);
    chk("t4.b_flush_cnt", 32'(b_fcnt), 2);

    // Taken branch during ext_stall never flushes
    clear_in();
    id_branch = 1; branch_taken = 1; ext_stall = 1;
    #1;
    chk_a("t4.frz_flush", 0, 0, 0);
    tick();
    chk("t4.frz_flush_cnt", 32'(a_fcnt), 2);

    // Test 5: ext_stall for 3 cycles mid-STALL
    ex_lw_branch(1'b0);
    #1;
    chk_a("t5.detect", 1, 0, 0);
    tick();
    ext_stall = 1;
    #1;
    chk("t5.cnt_entry", 32'(a_scnt), 4);
    for (int i = 0; i < 3; i++) begin
      chk_a("t5.frozen", 1, 0, 1);
      tick();
      chk("t5.frozen_cnt", 32'(a_scnt), 4);
    end
    ext_stall = 0;
    #1;
    chk_a("t5.release", 1, 0, 1);
    tick();
    chk_a("t5.resolve", 0, 0, 1);
    chk("t5.a_stall_cnt", 32'(a_scnt), 5);
    tick();
    id_branch = 0;
    #1;
    chk_a("t5.idle", 0, 0, 0);

    // Test 6: reset during STALL
    ex_lw_branch(1'b0);
    tick();
    #1;
    chk_a("t6.in_stall", 1, 0, 1);
    rst = 1;
    tick();
    chk_a("t6.after_rst", 1, 0, 0);
    chk("t6.a_stall_cnt", 32'(a_scnt), 0);
    chk("t6.a_flush_cnt", 32'(a_fcnt), 0);
    chk("t6.b_stall_cnt", 32'(b_scnt), 0);
    rst = 0;
    clear_in();
    #1;
    chk_a("t6.quiet", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
